// File: rtl/tea_round_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tea_round_scheduler
// Brief    : Round-robin two-port job arbiter and round sequencer driving the
//            strobes of a shared TEA encrypt/decrypt round datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tea_round_scheduler #(
  parameter int ROUNDS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_mode,
  output logic [1:0] req_ready,
  output logic       dp_sel,
  output logic       dp_load,
  output logic       dp_set_sum_enc,
  output logic       dp_set_sum_dec,
  output logic       dp_sum_inc,
  output logic       dp_sum_dec,
  output logic       dp_calc,
  output logic       dp_v_enc,
  output logic       dp_v_dec,
  output logic       dp_capture,
  output logic [4:0] round,
  output logic       busy,
  output logic       resp_valid,
  output logic       resp_id,
  output logic       resp_mode,
  input  logic       resp_ready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_INIT    = 3'd2;
  localparam logic [2:0] S_S0      = 3'd3;
  localparam logic [2:0] S_S1      = 3'd4;
  localparam logic [2:0] S_S2      = 3'd5;
  localparam logic [2:0] S_CAPTURE = 3'd6;
  localparam logic [2:0] S_RESP    = 3'd7;

  localparam logic [4:0] C_LAST_ROUND = 5'(ROUNDS - 1);

  logic [2:0] r_state;
  logic [4:0] r_round;
  logic       r_last_grant;
  logic       r_id;
  logic       r_mode;

  logic       w_any_req;
  logic       w_grant;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_any_req = |req_valid;
    w_grant   = (&req_valid) ? ~r_last_grant : req_valid[1];
    req_ready = 2'b00;
    if ((r_state == S_IDLE) && w_any_req && !reset) begin
      req_ready = w_grant ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_round      <= 5'd0;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_mode       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_id         <= w_grant;
            r_mode       <= req_mode[w_grant];
            r_last_grant <= w_grant;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_INIT;
        S_INIT: begin
          r_round <= 5'd0;
          r_state <= S_S0;
        end
        S_S0: r_state <= S_S1;
        S_S1: r_state <= S_S2;
        S_S2: begin
          if (r_round == C_LAST_ROUND) begin
            r_state <= S_CAPTURE;
          end else begin
            r_round <= r_round + 5'd1;
            r_state <= S_S0;
          end
        end
        S_CAPTURE: r_state <= S_RESP;
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Encrypt steps sum first; decrypt steps sum last, after the v update.
  assign dp_load        = (r_state == S_LOAD);
  assign dp_set_sum_enc = (r_state == S_INIT) && !r_mode;
  assign dp_set_sum_dec = (r_state == S_INIT) &&  r_mode;
  assign dp_sum_inc     = (r_state == S_S0)   && !r_mode;
  assign dp_calc        = ((r_state == S_S1) && !r_mode) || ((r_state == S_S0) && r_mode);
  assign dp_v_enc       = (r_state == S_S2)   && !r_mode;
  assign dp_v_dec       = (r_state == S_S1)   &&  r_mode;
  assign dp_sum_dec     = (r_state == S_S2)   &&  r_mode;
  assign dp_capture     = (r_state == S_CAPTURE);

  assign busy       = (r_state != S_IDLE);
  assign dp_sel     = busy && r_id;
  assign round      = r_round;
  assign resp_valid = (r_state == S_RESP);
  assign resp_id    = resp_valid && r_id;
  assign resp_mode  = resp_valid && r_mode;

endmodule
`default_nettype wire

// File: tb/tb_tea_round_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tea_round_scheduler
// Brief    : Directed self-checking bench for tea_round_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tea_round_scheduler;

  localparam int B_LOAD = 9, B_SENC = 8, B_SDEC = 7, B_INC = 6, B_DEC = 5;
  localparam int B_CALC = 4, B_VENC = 3, B_VDEC = 2, B_CAP = 1, B_RV = 0;

  logic clk = 1'b0;
  logic reset;

  logic [1:0] req_valid, req_mode, req_ready;
  logic       resp_ready;
  logic       dp_sel, dp_load, dp_set_sum_enc, dp_set_sum_dec, dp_sum_inc, dp_sum_dec;
  logic       dp_calc, dp_v_enc, dp_v_dec, dp_capture, busy, resp_valid, resp_id, resp_mode;
  logic [4:0] round;

  logic [1:0] req_valid_1, req_mode_1, req_ready_1;
  logic       resp_ready_1;
  logic       dp_sel_1, dp_load_1, dp_set_sum_enc_1, dp_set_sum_dec_1, dp_sum_inc_1, dp_sum_dec_1;
  logic       dp_calc_1, dp_v_enc_1, dp_v_dec_1, dp_capture_1, busy_1, resp_valid_1, resp_id_1, resp_mode_1;
  logic [4:0] round_1;

  tea_round_scheduler #(.ROUNDS(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
    .dp_sel(dp_sel), .dp_load(dp_load), .dp_set_sum_enc(dp_set_sum_enc),
    .dp_set_sum_dec(dp_set_sum_dec), .dp_sum_inc(dp_sum_inc), .dp_sum_dec(dp_sum_dec),
    .dp_calc(dp_calc), .dp_v_enc(dp_v_enc), .dp_v_dec(dp_v_dec), .dp_capture(dp_capture),
    .round(round), .busy(busy), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_mode(resp_mode), .resp_ready(resp_ready)
  );

  tea_round_scheduler #(.ROUNDS(1)) dut_1 (
    .clk(clk), .reset(reset), .req_valid(req_valid_1), .req_mode(req_mode_1), .req_ready(req_ready_1),
    .dp_sel(dp_sel_1), .dp_load(dp_load_1), .dp_set_sum_enc(dp_set_sum_enc_1),
    .dp_set_sum_dec(dp_set_sum_dec_1), .dp_sum_inc(dp_sum_inc_1), .dp_sum_dec(dp_sum_dec_1),
    .dp_calc(dp_calc_1), .dp_v_enc(dp_v_enc_1), .dp_v_dec(dp_v_dec_1), .dp_capture(dp_capture_1),
    .round(round_1), .busy(busy_1), .resp_valid(resp_valid_1), .resp_id(resp_id_1),
    .resp_mode(resp_mode_1), .resp_ready(resp_ready_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] obs, obs_1;
  assign obs   = {dp_load, dp_set_sum_enc, dp_set_sum_dec, dp_sum_inc, dp_sum_dec,
                  dp_calc, dp_v_enc, dp_v_dec, dp_capture, resp_valid};
  assign obs_1 = {dp_load_1, dp_set_sum_enc_1, dp_set_sum_dec_1, dp_sum_inc_1, dp_sum_dec_1,
                  dp_calc_1, dp_v_enc_1, dp_v_dec_1, dp_capture_1, resp_valid_1};

  int n_vec = 0;
  int n_err = 0;
  int last_grant_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] bit1(input int b);
    logic [9:0] v;
    v = 10'd1;
    return v << b;
  endfunction

  // Entered at the negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic job(input logic [1:0] valid, input logic [1:0] mode, input logic exp_id,
                     input bit hold_valid, input bit chk_spacing, input int stall);
    logic       m;
    logic [9:0] e;
    m          = mode[exp_id];
    req_valid  = valid;
    req_mode   = mode;
    resp_ready = (stall == 0);
    #1;
    chk("grant_ready", 32'(req_ready), exp_id ? 32'h2 : 32'h1);
    if (chk_spacing) chk("grant_spacing", 32'(cyc - last_grant_cyc), 32'd101);
    last_grant_cyc = cyc;
    @(negedge clk);
    chk("load", 32'(obs), 32'(bit1(B_LOAD)));
    chk("ready_busy", 32'(req_ready), 32'h0);
    chk("busy", 32'(busy), 32'h1);
    chk("sel", 32'(dp_sel), 32'(exp_id));
    if (!hold_valid) req_valid = 2'b00;
    @(negedge clk);
    chk("set_sum", 32'(obs), 32'(m ? bit1(B_SDEC) : bit1(B_SENC)));
    for (int r = 0; r < 32; r++) begin
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        if (!m) e = (s == 0) ? bit1(B_INC)  : (s == 1) ? bit1(B_CALC) : bit1(B_VENC);
        else    e = (s == 0) ? bit1(B_CALC) : (s == 1) ? bit1(B_VDEC) : bit1(B_DEC);
        chk("round_strobe", 32'(obs), 32'(e));
        chk("round_idx", 32'(round), 32'(r));
      end
    end
    chk("sel_rounds", 32'(dp_sel), 32'(exp_id));
    @(negedge clk);
    chk("capture", 32'(obs), 32'(bit1(B_CAP)));
    @(negedge clk);
    chk("resp", 32'(obs), 32'(bit1(B_RV)));
    chk("resp_id", 32'(resp_id), 32'(exp_id));
    chk("resp_mode", 32'(resp_mode), 32'(m));
    chk("sel_resp", 32'(dp_sel), 32'(exp_id));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("resp_hold", 32'({obs, resp_id, req_ready}), 32'({bit1(B_RV), exp_id, 2'b00}));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("back_idle", 32'({busy, resp_valid}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b00; req_mode = 2'b00; resp_ready = 1'b0;
    req_valid_1 = 2'b00; req_mode_1 = 2'b00; resp_ready_1 = 1'b0;
    #1;
    chk("reset_outputs", 32'({req_ready, obs, dp_sel, busy, resp_id, resp_mode, round}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Encrypt on requester 0, then decrypt on requester 1.
    job(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    job(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 0);

    // Both requesting: alternate grants at minimum spacing.
    job(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 0);
    job(2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 0);
    job(2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 0);
    job(2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 0);

    // Consumer stalls the completion for 10 cycles.
    job(2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 10);

    // Abort at round 17, step S1 (still in IDLE, valid=11, last grant 0).
    #1;
    chk("abort_grant", 32'(req_ready), 32'h2);
    repeat (55) @(negedge clk);
    chk("abort_round", 32'(round), 32'd17);
    chk("abort_state", 32'(obs), 32'(bit1(B_CALC)));
    #1 reset = 1'b1;
    #1;
    chk("abort_outputs", 32'({req_ready, obs, dp_sel, busy, resp_id, resp_mode, round}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    job(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 0);

    // Single-round configuration.
    req_valid_1 = 2'b01; req_mode_1 = 2'b00; resp_ready_1 = 1'b0;
    #1;
    chk("r1_grant", 32'(req_ready_1), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      case (k)
        1: chk("r1_load", 32'(obs_1), 32'(bit1(B_LOAD)));
        2: chk("r1_set", 32'(obs_1), 32'(bit1(B_SENC)));
        3: chk("r1_inc", 32'(obs_1), 32'(bit1(B_INC)));
        4: chk("r1_calc", 32'(obs_1), 32'(bit1(B_CALC)));
        5: chk("r1_venc", 32'(obs_1), 32'(bit1(B_VENC)));
        6: chk("r1_capture", 32'(obs_1), 32'(bit1(B_CAP)));
        7: chk("r1_resp", 32'(obs_1), 32'(bit1(B_RV)));
        default: chk("r1_idle", 32'({busy_1, obs_1}), 32'h0);
      endcase
      chk("r1_round", 32'(round_1), 32'h0);
      req_valid_1 = 2'b00;
      if (k == 7) resp_ready_1 = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
